mantissa_multiplier_seq: RTL and testbench

//  Sequential front stage of the FP32 multiplier; sits directly upstream of normalization_machine.

---
 rtl/mantissa_multiplier_seq_pkg.sv | 26 ++
 rtl/mantissa_multiplier_seq_if.sv | 36 +++
 rtl/mantissa_multiplier_seq_shift_add_core.sv | 64 ++++++
 rtl/mantissa_multiplier_seq.sv | 165 ++++++++++++++++
 tb/tb_mantissa_multiplier_seq.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/mantissa_multiplier_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mantissa_multiplier_seq_pkg
//  Description : Shared FP32 types and constants for the multiplier front stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mantissa_multiplier_seq_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] man;
  } fp32_t;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;
  localparam int FP_MAN_W   = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage : mantissa_multiplier_seq_pkg
`default_nettype wire

// File: rtl/mantissa_multiplier_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mantissa_multiplier_seq_if
//  Description : Operand/result handshake bundle of the mantissa multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mantissa_multiplier_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] fraction;
  logic [7:0]  exponent;
  logic        sign;
  logic        zero;
  logic        special;
  logic        exp_ovf;
  logic        exp_unf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, fraction, exponent, sign,
    input  zero, special, exp_ovf, exp_unf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, fraction, exponent, sign,
    output zero, special, exp_ovf, exp_unf
  );

endinterface : mantissa_multiplier_seq_if
`default_nettype wire

// File: rtl/mantissa_multiplier_seq_shift_add_core.sv
`default_nettype none
// ============================================================================
//  Module      : mantissa_multiplier_seq_shift_add_core
//  Description : Radix-2 shift-and-add mantissa multiplier, one bit per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mantissa_multiplier_seq_shift_add_core #(
  parameter int MAN_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [MAN_W-1:0] i_mcand,
  input  logic [MAN_W-1:0] i_mplier,
  output logic             o_last,
  output logic [MAN_W-1:0] o_product_hi
);

  localparam int                 c_cnt_w    = $clog2(MAN_W);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(MAN_W - 1);

  logic [2*MAN_W-1:0] r_acc;
  logic [2*MAN_W-1:0] r_mcand;
  logic [2*MAN_W-1:0] w_acc_next;
  logic [MAN_W-1:0]   r_mplier;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;

  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  // The top captures the product on the same edge as the final iteration,
  // so it sees the post-add value rather than the registered accumulator.
  assign o_last       = r_busy && (r_cnt == '0);
  assign o_product_hi = w_acc_next[2*MAN_W-1:MAN_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{MAN_W{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_cnt    <= c_cnt_init;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule : mantissa_multiplier_seq_shift_add_core
`default_nettype wire

// File: rtl/mantissa_multiplier_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mantissa_multiplier_seq
//  Description : FP32 multiply front stage: unpack, exponent add, sign, and
//                sequential 24x24 mantissa product for the normalizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module mantissa_multiplier_seq
  import mantissa_multiplier_seq_pkg::*;
#(
  parameter int MAN_W = FP_MAN_W,
  parameter int EXP_W = 8,
  parameter int BIAS  = FP_BIAS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mantissa_multiplier_seq_if.slave  bus
);

  localparam logic        [EXP_W-1:0] c_exp_max = EXP_W'(FP_EXP_MAX);
  localparam logic        [EXP_W+1:0] c_bias    = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] c_sum_hi  = (EXP_W+2)'(FP_EXP_MAX - 1);
  localparam logic signed [EXP_W+1:0] c_sum_lo  = (EXP_W+2)'(1);

  mul_state_e r_state;
  mul_state_e w_state_next;

  fp32_t                    w_a;
  fp32_t                    w_b;
  logic [EXP_W-1:0]         w_ea;
  logic [EXP_W-1:0]         w_eb;
  logic signed [EXP_W+1:0]  w_sum;
  logic                     w_zero;
  logic                     w_special;
  logic                     w_ovf;
  logic                     w_unf;
  logic                     w_short;
  logic [EXP_W-1:0]         w_exp_result;

  logic                     w_accept;
  logic                     w_start;
  logic                     w_capture;
  logic                     w_core_last;
  logic [MAN_W-1:0]         w_core_product;

  logic [MAN_W-1:0]         r_fraction;
  logic [EXP_W-1:0]         r_exponent;
  logic                     r_sign;
  logic                     r_zero;
  logic                     r_special;
  logic                     r_ovf;
  logic                     r_unf;

  assign w_a  = bus.a;
  assign w_b  = bus.b;
  assign w_ea = w_a.exp;
  assign w_eb = w_b.exp;

  // Ten-bit signed sum covers the full range -127..383 without wrap.
  assign w_sum     = {2'b00, w_ea} + {2'b00, w_eb} - c_bias;
  assign w_zero    = (w_ea == '0) || (w_eb == '0);
  assign w_special = (w_ea == c_exp_max) || (w_eb == c_exp_max);
  assign w_ovf     = !w_zero && !w_special && (w_sum > c_sum_hi);
  assign w_unf     = !w_zero && !w_special && (w_sum < c_sum_lo);
  assign w_short   = w_zero || w_special || w_ovf || w_unf;

  always_comb begin
    w_exp_result = w_sum[EXP_W-1:0];
    if (w_special) begin
      w_exp_result = c_exp_max;
    end else if (w_zero) begin
      w_exp_result = '0;
    end else if (w_ovf) begin
      w_exp_result = c_exp_max;
    end else if (w_unf) begin
      w_exp_result = '0;
    end
  end

  mantissa_multiplier_seq_shift_add_core #(
    .MAN_W (MAN_W)
  ) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_start),
    .i_mcand      ({1'b1, w_a.man}),
    .i_mplier     ({1'b1, w_b.man}),
    .o_last       (w_core_last),
    .o_product_hi (w_core_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          if (w_short) begin
            w_state_next = DONE;
          end else begin
            w_start      = 1'b1;
            w_state_next = MUL;
          end
        end
      end
      MUL: begin
        if (w_core_last) begin
          w_capture    = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fraction <= '0;
      r_exponent <= '0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_special  <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else if (w_accept) begin
      r_fraction <= '0;
      r_exponent <= w_exp_result;
      r_sign     <= w_a.sign ^ w_b.sign;
      r_zero     <= w_zero;
      r_special  <= w_special;
      r_ovf      <= w_ovf;
      r_unf      <= w_unf;
    end else if (w_capture) begin
      r_fraction <= w_core_product;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.fraction  = r_fraction;
  assign bus.exponent  = r_exponent;
  assign bus.sign      = r_sign;
  assign bus.zero      = r_zero;
  assign bus.special   = r_special;
  assign bus.exp_ovf   = r_ovf;
  assign bus.exp_unf   = r_unf;

endmodule : mantissa_multiplier_seq
`default_nettype wire

// File: tb/tb_mantissa_multiplier_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mantissa_multiplier_seq
//  Description : Directed self-checking bench for mantissa_multiplier_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mantissa_multiplier_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  mantissa_multiplier_seq_if bus_if ();

  mantissa_multiplier_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] opa, input logic [31:0] opb);
    @(negedge clk);
    bus_if.a        = opa;
    bus_if.b        = opb;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus_if.out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_out(input string tag, input logic [23:0] efrac, input logic [7:0] eexp,
                           input logic esign, input logic [3:0] eflg);
    check({tag, ".frac"}, {8'h0, bus_if.fraction}, {8'h0, efrac});
    check({tag, ".exp"},  {24'h0, bus_if.exponent}, {24'h0, eexp});
    check({tag, ".sign"}, {31'h0, bus_if.sign}, {31'h0, esign});
    check({tag, ".flags"},
          {28'h0, bus_if.zero, bus_if.special, bus_if.exp_ovf, bus_if.exp_unf},
          {28'h0, eflg});
    check({tag, ".rdy"}, {31'h0, bus_if.in_ready}, 32'h0);
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
    check({tag, ".idle"}, {30'h0, bus_if.out_valid, bus_if.in_ready}, 32'h1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] opa, input logic [31:0] opb,
                        input logic [23:0] efrac, input logic [7:0] eexp, input logic esign,
                        input logic [3:0] eflg, input int elat);
    int lat;
    start_op(opa, opb);
    wait_valid(lat);
    check({tag, ".lat"}, lat, elat);
    check_out(tag, efrac, eexp, esign, eflg);
    finish_op(tag);
  endtask

  initial begin
    int lat;
    n_checks         = 0;
    n_fails          = 0;
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.hs", {30'h0, bus_if.in_ready, bus_if.out_valid}, 32'h2);
    check("rst.frac", {8'h0, bus_if.fraction}, 32'h0);
    check("rst.exp", {24'h0, bus_if.exponent}, 32'h0);
    check("rst.flags", {27'h0, bus_if.sign, bus_if.zero, bus_if.special,
                        bus_if.exp_ovf, bus_if.exp_unf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // flags order: {zero, special, exp_ovf, exp_unf}
    run_op("one",    32'h3F800000, 32'h3F800000, 24'h400000, 8'h7F, 1'b0, 4'b0000, 25);
    run_op("sq15",   32'h3FC00000, 32'h3FC00000, 24'h900000, 8'h7F, 1'b0, 4'b0000, 25);
    run_op("neg6",   32'hC0000000, 32'h40400000, 24'h600000, 8'h81, 1'b1, 4'b0000, 25);
    run_op("maxman", 32'h3FFFFFFF, 32'h3FFFFFFF, 24'hFFFFFE, 8'h7F, 1'b0, 4'b0000, 25);
    run_op("zero",   32'h00000000, 32'h3F800000, 24'h000000, 8'h00, 1'b0, 4'b1000, 1);
    run_op("nzero",  32'h80000000, 32'h3F800000, 24'h000000, 8'h00, 1'b1, 4'b1000, 1);
    run_op("ovf",    32'h7E800000, 32'h7E800000, 24'h000000, 8'hFF, 1'b0, 4'b0010, 1);
    run_op("ninf",   32'hFF800000, 32'h3F800000, 24'h000000, 8'hFF, 1'b1, 4'b0100, 1);
    run_op("infz",   32'h7F800000, 32'h00000000, 24'h000000, 8'hFF, 1'b0, 4'b1100, 1);
    run_op("e254",   32'h7F000000, 32'h3F800000, 24'h400000, 8'hFE, 1'b0, 4'b0000, 25);
    run_op("e255",   32'h7F000000, 32'h40000000, 24'h000000, 8'hFF, 1'b0, 4'b0010, 1);
    run_op("e1",     32'h00800000, 32'h3F800000, 24'h400000, 8'h01, 1'b0, 4'b0000, 25);
    run_op("e0",     32'h00800000, 32'h3F000000, 24'h000000, 8'h00, 1'b0, 4'b0001, 1);

    // Back-pressure: 1.5 * 3.0 = 4.5 held for 10 cycles while new operands are offered.
    start_op(32'h3FC00000, 32'h40400000);
    wait_valid(lat);
    check("bp.lat", lat, 25);
    bus_if.a        = 32'h3F800000;
    bus_if.b        = 32'h3F800000;
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp.hold", {bus_if.out_valid, bus_if.in_ready, bus_if.sign, 5'h0,
                        bus_if.fraction}, {1'b1, 1'b0, 1'b0, 5'h0, 24'h900000});
      check("bp.exp", {24'h0, bus_if.exponent}, 32'h80);
    end
    bus_if.in_valid = 1'b0;
    finish_op("bp");

    // Asynchronous reset in the middle of a multiplication.
    start_op(32'h40400000, 32'h40400000);
    repeat (9) @(posedge clk);
    #1;
    check("ab.busy", {30'h0, bus_if.out_valid, bus_if.in_ready}, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    check("ab.hs", {30'h0, bus_if.out_valid, bus_if.in_ready}, 32'h1);
    check("ab.exp", {24'h0, bus_if.exponent}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post", 32'h3FC00000, 32'h3FC00000, 24'h900000, 8'h7F, 1'b0, 4'b0000, 25);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule : tb_mantissa_multiplier_seq
`default_nettype wire
